// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter for the register file write port: merges EX and LSU writes into an
// in-order FIFO and forwards pending (not yet written) values to the decode read ports.
module ibex_rf_wb_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,

    input  logic                 lsu_we_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_a_valid_o,
    output logic [DataWidth-1:0] fwd_a_data_o,
    output logic                 fwd_b_valid_o,
    output logic [DataWidth-1:0] fwd_b_data_o,

    output logic                 idle_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [4:0]           addr_q [Depth];
    logic [DataWidth-1:0] data_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, wptr_inc;
    logic [CntW-1:0]      count_q, count_d;

    logic [4:0] ex_addr, lsu_addr, ra_addr, rb_addr;
    logic       ex_push, lsu_push, pop;

    // Bit 4 carries no meaning on RV32E, so it is stripped before storing or comparing.
    function automatic logic [4:0] eff_addr(input logic [4:0] a);
        return RV32E ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ex_addr  = eff_addr(ex_waddr_i);
    assign lsu_addr = eff_addr(lsu_waddr_i);
    assign ra_addr  = eff_addr(raddr_a_i);
    assign rb_addr  = eff_addr(raddr_b_i);

    // At most Depth-2 entries leave room for a simultaneous LSU write.
    assign ex_ready_o = ~rst_i & (count_q <= CntW'(Depth - 2));
    assign ex_push    = ex_we_i & ex_ready_o & (ex_addr != 5'd0);
    assign lsu_push   = ~rst_i & lsu_we_i & (lsu_addr != 5'd0);
    assign pop        = (count_q != '0);

    assign wptr_inc = ptr_inc(wptr_q);

    always_comb begin
        wptr_d = wptr_q;
        if (ex_push && lsu_push) begin
            wptr_d = ptr_inc(wptr_inc);
        end else if (ex_push || lsu_push) begin
            wptr_d = wptr_inc;
        end
        count_d = count_q + CntW'(lsu_push) + CntW'(ex_push) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= pop ? ptr_inc(rptr_q) : rptr_q;
            count_q <= count_d;
        end
    end

    // LSU entry is older than a same-cycle EX entry, so it takes the first slot.
    always_ff @(posedge clk_i) begin
        if (lsu_push) begin
            addr_q[wptr_q] <= lsu_addr;
            data_q[wptr_q] <= lsu_wdata_i;
        end
        if (ex_push) begin
            addr_q[lsu_push ? wptr_inc : wptr_q] <= ex_addr;
            data_q[lsu_push ? wptr_inc : wptr_q] <= ex_wdata_i;
        end
    end

    assign rf_we_o    = pop & ~rst_i;
    assign rf_waddr_o = rf_we_o ? addr_q[rptr_q] : 5'd0;
    assign rf_wdata_o = rf_we_o ? data_q[rptr_q] : '0;
    assign idle_o     = (count_q == '0);

    logic                 fa_valid, fb_valid;
    logic [DataWidth-1:0] fa_data, fb_data;
    logic [PtrW-1:0]      idx;

    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        fa_valid = 1'b0;
        fa_data  = '0;
        fb_valid = 1'b0;
        fb_data  = '0;
        idx      = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            idx = PtrW'((32'(rptr_q) + i) % Depth);
            if (i < 32'(count_q)) begin
                if (ra_addr != 5'd0 && addr_q[idx] == ra_addr) begin
                    fa_valid = 1'b1;
                    fa_data  = data_q[idx];
                end
                if (rb_addr != 5'd0 && addr_q[idx] == rb_addr) begin
                    fb_valid = 1'b1;
                    fb_data  = data_q[idx];
                end
            end
        end
    end

    assign fwd_a_valid_o = fa_valid & ~rst_i;
    assign fwd_a_data_o  = rst_i ? '0 : fa_data;
    assign fwd_b_valid_o = fb_valid & ~rst_i;
    assign fwd_b_data_o  = rst_i ? '0 : fb_data;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter: a queue model predicts every output each cycle,
// plus hand-computed checks at the points of interest; an RV32E copy checks address masking.
module tb_ibex_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_we_i, lsu_we_i;
    logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
    logic [31:0] ex_wdata_i, lsu_wdata_i;

    logic        ex_ready_o, rf_we_o, fwd_a_valid_o, fwd_b_valid_o, idle_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, fwd_a_data_o, fwd_b_data_o;

    logic        e_ex_ready, e_rf_we, e_fa_valid, e_fb_valid, e_idle;
    logic [4:0]  e_rf_waddr;
    logic [31:0] e_rf_wdata, e_fa_data, e_fb_data;

    int n_vec = 0;
    int n_err = 0;
    int n_rf_writes = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    ibex_rf_wb_arbiter #(.DataWidth(32), .RV32E(1'b0), .Depth(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
        .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o),
        .idle_o(idle_o)
    );

    ibex_rf_wb_arbiter #(.DataWidth(32), .RV32E(1'b1), .Depth(4)) dut_e (
        .clk_i(clk), .rst_i(rst_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(e_ex_ready),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .fwd_a_valid_o(e_fa_valid), .fwd_a_data_o(e_fa_data),
        .fwd_b_valid_o(e_fb_valid), .fwd_b_data_o(e_fb_data),
        .idle_o(e_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, clock, update model.
    task automatic tick(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                        input logic lw, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] ra, input logic [4:0] rb, output logic ex_acc);
        logic        exp_rdy, fva, fvb;
        logic [31:0] fda, fdb;
        int          pre, npush;
        ent_t        e;
        ex_we_i = ew;  ex_waddr_i = ea;  ex_wdata_i = ed;
        lsu_we_i = lw; lsu_waddr_i = la; lsu_wdata_i = ld;
        raddr_a_i = ra; raddr_b_i = rb;
        #1;
        pre = q.size();
        exp_rdy = (pre <= 2);
        fva = 1'b0; fda = '0; fvb = 1'b0; fdb = '0;
        foreach (q[i]) begin
            if (ra != 5'd0 && q[i].a == ra) begin fva = 1'b1; fda = q[i].d; end
            if (rb != 5'd0 && q[i].a == rb) begin fvb = 1'b1; fdb = q[i].d; end
        end
        chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, exp_rdy});
        chk("rf_we", {31'd0, rf_we_o}, {31'd0, pre != 0});
        chk("rf_waddr", {27'd0, rf_waddr_o}, (pre != 0) ? {27'd0, q[0].a} : 32'd0);
        chk("rf_wdata", rf_wdata_o, (pre != 0) ? q[0].d : 32'd0);
        chk("fwd_a_valid", {31'd0, fwd_a_valid_o}, {31'd0, fva});
        chk("fwd_a_data", fwd_a_data_o, fda);
        chk("fwd_b_valid", {31'd0, fwd_b_valid_o}, {31'd0, fvb});
        chk("fwd_b_data", fwd_b_data_o, fdb);
        chk("idle", {31'd0, idle_o}, {31'd0, pre == 0});
        if (rf_we_o === 1'b1) n_rf_writes++;
        ex_acc = ew && exp_rdy && (ea != 5'd0);
        npush = int'(lw && la != 5'd0) + int'(ex_acc);
        chk("no_dual_push_at_depth_m1", {31'd0, (pre == 3 && npush == 2)}, 32'd0);
        @(posedge clk);
        if (pre != 0) void'(q.pop_front());
        if (lw && la != 5'd0) begin e.a = la; e.d = ld; q.push_back(e); end
        if (ex_acc) begin e.a = ea; e.d = ed; q.push_back(e); end
        #1;
    endtask

    // Reset for one cycle with a live LSU write that must be ignored.
    task automatic do_reset();
        rst_i = 1'b1;
        ex_we_i = 1'b1; ex_waddr_i = 5'd6; ex_wdata_i = 32'h66;
        lsu_we_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h77;
        #1;
        chk("ex_ready_in_reset", {31'd0, ex_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        ex_we_i = 1'b0; lsu_we_i = 1'b0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   base, ex_n, i;
        raddr_a_i = 5'd0; raddr_b_i = 5'd0;
        do_reset();
        chk("reset_idle", {31'd0, idle_o}, 32'd1);
        chk("reset_rf_we", {31'd0, rf_we_o}, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 5'd5, 5'd3, acc);

        // Single EX write
        tick(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd0, 5'd0, acc);
        chk("single_rf_we", {31'd0, rf_we_o}, 32'd1);
        chk("single_rf_waddr", {27'd0, rf_waddr_o}, 32'd5);
        chk("single_rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        tick(0, 0, 0, 0, 0, 0, 5'd5, 5'd0, acc);
        chk("single_idle_after", {31'd0, idle_o}, 32'd1);

        // Same-cycle dual push to r3: LSU older, EX younger
        tick(1, 5'd3, 32'h22, 1, 5'd3, 32'h11, 5'd3, 5'd0, acc);
        chk("dual_c2_waddr", {27'd0, rf_waddr_o}, 32'd3);
        chk("dual_c2_wdata", rf_wdata_o, 32'h11);
        chk("dual_c2_fwd_valid", {31'd0, fwd_a_valid_o}, 32'd1);
        chk("dual_c2_fwd_data", fwd_a_data_o, 32'h22);
        tick(0, 0, 0, 0, 0, 0, 5'd3, 5'd0, acc);
        chk("dual_c3_wdata", rf_wdata_o, 32'h22);
        chk("dual_c3_fwd_valid", {31'd0, fwd_a_valid_o}, 32'd1);
        chk("dual_c3_fwd_data", fwd_a_data_o, 32'h22);
        tick(0, 0, 0, 0, 0, 0, 5'd3, 5'd0, acc);
        chk("dual_c4_fwd_valid", {31'd0, fwd_a_valid_o}, 32'd0);
        chk("dual_c4_idle", {31'd0, idle_o}, 32'd1);

        // x0 drop, then r16 which only the RV32E copy drops
        tick(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, 5'd0, 5'd0, acc);
        chk("x0_idle", {31'd0, idle_o}, 32'd1);
        chk("x0_rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("x0_ex_ready", {31'd0, ex_ready_o}, 32'd1);
        tick(1, 5'd16, 32'h55, 1, 5'd16, 32'h44, 5'd16, 5'd0, acc);
        chk("e16_rf_we", {31'd0, e_rf_we}, 32'd0);
        chk("e16_idle", {31'd0, e_idle}, 32'd1);
        chk("e16_ex_ready", {31'd0, e_ex_ready}, 32'd1);
        chk("r16_main_waddr", {27'd0, rf_waddr_o}, 32'd16);
        chk("r16_main_wdata", rf_wdata_o, 32'h44);
        tick(0, 0, 0, 0, 0, 0, 5'd16, 5'd0, acc);
        tick(0, 0, 0, 0, 0, 0, 5'd16, 5'd0, acc);

        // Backpressure: LSU every cycle, then every other cycle; EX held until accepted
        ex_n = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1, 5'(8 + (ex_n % 4)), 32'hE000 + 32'(ex_n),
                 (c < 6) || (c % 2 == 0), 5'(20 + (c % 3)), 32'hF000 + 32'(c),
                 5'(8 + (ex_n % 4)), 5'(20 + (c % 3)), acc);
            if (c == 2) chk("bp_stalled_at_3", {31'd0, ex_ready_o}, 32'd0);
            if (acc) ex_n++;
        end
        for (int c = 0; c < 6; c++) tick(0, 0, 0, 0, 0, 0, 5'd9, 5'd21, acc);
        chk("bp_drained", {31'd0, idle_o}, 32'd1);
        chk("bp_ex_progress", {31'd0, ex_n > 5}, 32'd1);

        // Wrap-around: 12 EX writes, one per cycle
        do_reset();
        base = n_rf_writes;
        for (i = 1; i <= 12; i++) begin
            tick(1, 5'(i), 32'hA000 + 32'(i), 0, 0, 0, 5'(i), 5'(i - 1), acc);
            chk("wrap_head_waddr", {27'd0, rf_waddr_o}, 32'(i));
        end
        tick(0, 0, 0, 0, 0, 0, 5'd12, 5'd11, acc);
        chk("wrap_write_count", 32'(n_rf_writes - base), 32'd12);

        // Reset mid-operation with 3 entries queued
        tick(1, 5'd8, 32'h88, 1, 5'd7, 32'h77, 5'd0, 5'd0, acc);
        tick(1, 5'd10, 32'h1010, 1, 5'd9, 32'h99, 5'd9, 5'd10, acc);
        chk("mid_fill_not_ready", {31'd0, ex_ready_o}, 32'd0);
        do_reset();
        raddr_a_i = 5'd9; raddr_b_i = 5'd10;
        #1;
        chk("mid_rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("mid_fwd_a_valid", {31'd0, fwd_a_valid_o}, 32'd0);
        chk("mid_fwd_b_valid", {31'd0, fwd_b_valid_o}, 32'd0);
        chk("mid_idle", {31'd0, idle_o}, 32'd1);
        for (int c = 0; c < 4; c++) tick(0, 0, 0, 0, 0, 0, 5'd9, 5'd7, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
